// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit unsigned multiply/divide unit.
// One shift/add (MUL, MULHU) or shift/subtract (DIVU, REMU) step per clock.
// The result goes straight to the register-file write port.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd,
  input  logic            kill,
  output logic            busy,
  output logic            wb_valid,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic              valid_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     mul_sel;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   sub_diff;
  logic              sub_borrow;
  logic              sub_ok;
  logic [XLEN-1:0]   hi_next;
  logic [XLEN-1:0]   lo_next;
  logic [XLEN-1:0]   result_next;
  logic              last_iter;

  // acc_hi holds the upper product half or the partial remainder; acc_lo
  // holds the multiplier (shifting out) or dividend/quotient (shifting in).
  // opnd holds the multiplicand or the divisor.
  always_comb begin
    mul_sum                = {1'b0, acc_hi} + {1'b0, opnd};
    mul_sel                = acc_lo[0] ? mul_sum : {1'b0, acc_hi};
    rem_sh                 = {acc_hi, acc_lo[XLEN-1]};
    {sub_borrow, sub_diff} = {1'b0, rem_sh[XLEN-1:0]} - {1'b0, opnd};
    sub_ok                 = rem_sh[XLEN] | ~sub_borrow;
    hi_next                = '0;
    lo_next                = '0;
    if (op_q[1]) begin
      hi_next = sub_ok ? sub_diff : rem_sh[XLEN-1:0];
      lo_next = {acc_lo[XLEN-2:0], sub_ok};
    end else begin
      hi_next = mul_sel[XLEN:1];
      lo_next = {mul_sel[0], acc_lo[XLEN-1:1]};
    end
    result_next = op_q[0] ? hi_next : lo_next;
    last_iter   = (cnt == CNT_W'(XLEN - 1));
  end

  // A flush during the completion cycle must suppress the write immediately.
  assign wb_valid = valid_q & ~kill;
  assign wb_en    = wb_valid & (wb_addr != 5'd0);

  // Control FSM together with the iterating datapath and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            rd_q   <= rd;
            acc_hi <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            if (op[1]) begin
              acc_lo <= src_a;
              opnd   <= src_b;
            end else begin
              acc_lo <= src_b;
              opnd   <= src_a;
            end
            if (op[1] && (src_b == '0)) begin
              state   <= DONE;
              valid_q <= 1'b1;
              wb_addr <= rd;
              wb_data <= op[0] ? src_a : '1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
              state   <= DONE;
              valid_q <= 1'b1;
              wb_addr <= rd_q;
              wb_data <= result_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit with fixed vectors,
// random operations against an arithmetic model, and flush/reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd;
  logic        kill;
  logic        busy;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          exp_cyc;
  } vec_t;

  muldiv_unit dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .rd(rd), .kill(kill), .busy(busy), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, scramble inputs after acceptance, and check the pulse.
  task automatic apply_stimulus(input string name, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] r,
                                input logic [31:0] exp, input int exp_cyc);
    int cyc;
    int busy_drop;
    @(negedge clk);
    op = o; src_a = a; src_b = b; rd = r; start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom; rd = 5'($urandom);
    cyc = 1;
    busy_drop = 0;
    check_output($sformatf("%s busy_c1", name), 64'(busy), 64'd1);
    while (!wb_valid && cyc < 40) begin
      tick();
      cyc++;
      if (!busy) busy_drop++;
    end
    check_output($sformatf("%s pulse_cycle", name), 64'(cyc), 64'(exp_cyc));
    check_output($sformatf("%s busy_drop", name), 64'(busy_drop), 64'd0);
    check_output($sformatf("%s wb_data", name), 64'(wb_data), 64'(exp));
    check_output($sformatf("%s wb_addr", name), 64'(wb_addr), 64'(r));
    check_output($sformatf("%s wb_en", name), 64'(wb_en), 64'(r != 5'd0));
    tick();
    check_output($sformatf("%s idle_busy", name), 64'(busy), 64'd0);
    check_output($sformatf("%s idle_valid", name), 64'(wb_valid), 64'd0);
    check_output($sformatf("%s hold_data", name), 64'(wb_data), 64'(exp));
  endtask

  initial begin
    vec_t vecs[10];
    int   pulses;
    int   pulse_cyc;
    int   en_seen;
    logic [31:0] pulse_data;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rr;

    vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         33};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE,  33};
    vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001,  33};
    vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd3,  32'd14,         33};
    vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          33};
    vecs[5] = '{2'b10, 32'd123,        32'd0,          5'd6,  32'hFFFF_FFFF,  1};
    vecs[6] = '{2'b11, 32'd123,        32'd0,          5'd7,  32'd123,        1};
    vecs[7] = '{2'b10, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33};
    vecs[8] = '{2'b11, 32'd5,          32'hFFFF_FFFF,  5'd9,  32'd5,          33};
    vecs[9] = '{2'b10, 32'd7,          32'd9,          5'd11, 32'd0,          33};

    clr_n = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00;
    src_a = '0; src_b = '0; rd = '0;
    #2 clr_n = 1'b0;
    #1;
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset wb_valid", 64'(wb_valid), 64'd0);
    check_output("reset wb_en", 64'(wb_en), 64'd0);
    check_output("reset wb_addr", 64'(wb_addr), 64'd0);
    check_output("reset wb_data", 64'(wb_data), 64'd0);
    tick();
    tick();
    clr_n = 1'b1;

    for (int i = 0; i < 10; i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                     vecs[i].exp, vecs[i].exp_cyc);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      rr = 5'($urandom);
      apply_stimulus($sformatf("rand%0d", i), ro, ra, rb, rr, ref_model(ro, ra, rb),
                     (ro[1] && rb == 0) ? 1 : 33);
    end

    // rd=0 multiply with ignored start requests at cycles 5 and 33.
    @(negedge clk);
    op = 2'b00; src_a = 32'd3; src_b = 32'd3; rd = 5'd0; start = 1'b1;
    tick();
    pulses = 0; pulse_cyc = 0; en_seen = 0; pulse_data = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (wb_valid) begin
        pulses++;
        pulse_cyc = cyc;
        pulse_data = wb_data;
      end
      if (wb_en) en_seen++;
      if (cyc == 34) check_output("rd0 busy_c34", 64'(busy), 64'd0);
      if (cyc == 5 || cyc == 33) begin
        start = 1'b1; op = 2'b10; src_a = 32'd77; src_b = 32'd0; rd = 5'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check_output("rd0 pulses", 64'(pulses), 64'd1);
    check_output("rd0 pulse_cycle", 64'(pulse_cyc), 64'd33);
    check_output("rd0 wb_data", 64'(pulse_data), 64'd9);
    check_output("rd0 wb_en_seen", 64'(en_seen), 64'd0);

    // Flush a division at cycle 10.
    @(negedge clk);
    op = 2'b10; src_a = 32'd1000; src_b = 32'd3; rd = 5'd8; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (wb_valid) pulses++;
      if (cyc == 11) check_output("kill busy_c11", 64'(busy), 64'd0);
      kill = (cyc == 10);
      tick();
    end
    kill = 1'b0;
    check_output("kill pulses", 64'(pulses), 64'd0);
    check_output("kill wb_addr_hold", 64'(wb_addr), 64'd0);

    // Asynchronous reset in the middle of a multiply, then a fresh multiply.
    @(negedge clk);
    op = 2'b00; src_a = 32'h1234; src_b = 32'h10; rd = 5'd12; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) tick();
    clr_n = 1'b0;
    #1;
    check_output("clr busy", 64'(busy), 64'd0);
    check_output("clr wb_valid", 64'(wb_valid), 64'd0);
    check_output("clr wb_en", 64'(wb_en), 64'd0);
    check_output("clr wb_addr", 64'(wb_addr), 64'd0);
    check_output("clr wb_data", 64'(wb_data), 64'd0);
    tick();
    clr_n = 1'b1;
    apply_stimulus("post_clr", 2'b00, 32'h1234, 32'h10, 5'd12, 32'h12340, 33);

    // Start with kill in IDLE is accepted; kill during DONE suppresses the write.
    @(negedge clk);
    op = 2'b11; src_a = 32'd55; src_b = 32'd0; rd = 5'd10; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    #1;
    check_output("sk busy", 64'(busy), 64'd1);
    check_output("sk wb_valid", 64'(wb_valid), 64'd1);
    check_output("sk wb_data", 64'(wb_data), 64'd55);
    kill = 1'b1;
    #1;
    check_output("done_kill wb_valid", 64'(wb_valid), 64'd0);
    check_output("done_kill wb_en", 64'(wb_en), 64'd0);
    tick();
    kill = 1'b0;
    check_output("done_kill busy", 64'(busy), 64'd0);
    check_output("done_kill valid_after", 64'(wb_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit unsigned multiply/divide execution unit. Operands come from the register-file read ports.
- Its write-back outputs drive the register-file write port directly: wb_addr to writeaddr, wb_data to write_data, wb_en to write_cntrl.
- Handles MUL, MULHU, DIVU and REMU in a fixed 32-iteration shift/add or shift/subtract loop.
- Holds the pipeline with a busy flag while an operation is running.

Parameters:
- XLEN, 32, operand and result width. The iteration count equals XLEN.
- CNT_W, 5, iteration counter width. Equals log2(XLEN).

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Accepted only when busy=0.
- op  in  2  00 MUL (low 32 bits of product), 01 MULHU (high 32 bits), 10 DIVU (quotient), 11 REMU (remainder).
- src_a  in  XLEN  multiplicand or dividend, from the register-file read1 port.
- src_b  in  XLEN  multiplier or divisor, from the register-file read2 port.
- rd  in  5  destination register address.
- kill  in  1  abort of the in-flight operation (pipeline flush).
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- wb_valid  out  1  one-cycle completion pulse.
- wb_en  out  1  register-file write enable. Equals wb_valid AND (wb_addr != 0).
- wb_addr  out  5  registered copy of rd.
- wb_data  out  XLEN  result.

Behaviour:
- Reset: clr_n=0 asynchronously forces state=IDLE, busy=0, wb_valid=0, wb_en=0, wb_addr=0, wb_data=0, and clears the counter and all datapath registers.
- FSM states: IDLE, CALC, DONE.
- IDLE, on start=1 at edge E0:
  - latch op, rd, src_a and src_b;
  - clear the 64-bit accumulator / partial remainder;
  - cnt<=0;
  - go to CALC.
- If src_b=0 and op is DIVU or REMU at E0, go straight to DONE with quotient=all ones (32'hFFFF_FFFF) and remainder=src_a. The pulse then appears in cycle 1.
- CALC: one iteration per edge.
  - MUL/MULHU: shift-add. If the multiplier LSB=1, add the multiplicand to the upper half of the product (33-bit add, carry kept). Then shift the product right by 1.
  - DIVU/REMU: restoring division. Shift {rem, quot} left by 1, trial-subtract the divisor (33-bit), and if the result is non-negative keep it and set the quotient LSB.
  - When cnt reaches XLEN-1, the edge performs the last iteration and moves to DONE.
- DONE: lasts exactly one cycle.
  - wb_valid=1 and wb_data holds the result selected by op.
  - The next edge returns to IDLE.
- Latency: acceptance edge E0; the 32 iterations occur on edges E1..E32; wb_valid is high in the cycle after E32 (cycle 33). busy is high in cycles 1..33.
- A start asserted on the same edge that leaves DONE is ignored; busy is still high in that cycle. Back-to-back throughput is one operation per 34 cycles.
- start while busy=1 is ignored. No queueing.
- Operands are sampled only at E0. Later changes on src_a, src_b, rd and op have no effect.
- rd=0: the result is computed and wb_valid pulses, but wb_en stays 0.
- kill=1 in CALC or DONE: next state is IDLE, wb_valid and wb_en are forced 0 in that cycle, and no write occurs. kill in IDLE has no effect. If start and kill are both high in IDLE, start is accepted.
- clr_n asserted mid-operation aborts immediately with no write. After release the unit accepts start on the first clock edge.
- wb_data and wb_addr hold their values after DONE until the next completion.

Test Plan:
- MUL 7 x 6, rd=5 -> in cycle 33, wb_valid=1, wb_en=1, wb_addr=5, wb_data=42. busy is low in cycle 34.
- MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> wb_data=0xFFFF_FFFE. MUL on the same operands -> wb_data=0x0000_0001.
- DIVU 100/7 -> wb_data=14. REMU 100/7 -> wb_data=2. Both pulse in cycle 33.
- DIVU 123/0 -> wb_data=0xFFFF_FFFF in cycle 1. REMU 123/0 -> wb_data=123 in cycle 1.
- rd=0 with MUL 3x3 -> wb_valid=1, wb_en=0. start re-asserted at cycles 5 and 33 -> both ignored, and exactly one pulse is seen.
- kill at cycle 10 of a DIVU -> no wb_valid and busy=0 in cycle 11. clr_n pulsed low at cycle 20 of a MUL -> all outputs 0 immediately, and a new MUL accepted after release completes correctly.
